alu_ctrl_stage: RTL

ALU_CTRL_STAGE -- requirements
Module: alu_ctrl_stage

---
 rtl/alu_ctrl_stage.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_stage.sv
// -----------------------------------------------------------------------------
// alu_ctrl_stage
// Single registered decode stage that turns a MIPS-style opcode/funct/immediate
// into ALU control: the ALU operation code, the operand-B select, the shift
// amount select, and the extended immediate. Unsupported encodings are flagged
// as illegal, and the stage keeps a saturating count of accepted illegal
// instructions. A valid/ready handshake on both sides gives full throughput.
//
// Ports
//   clock, reset        : single clock, synchronous active-high reset
//   flush               : drop the held entry and refuse input this cycle
//   in_valid / in_ready : upstream handshake (in_ready is combinational)
//   opcode, funct, imm  : raw instruction fields
//   out_valid/out_ready : downstream handshake
//   funct_for_alu       : ALU operation code
//   alu_src_imm         : operand B is imm_ext (1) or a register (0)
//   shift_src_shamt     : shift amount from shamt (1) or rs (0)
//   imm_ext             : extended immediate (0 for non-immediate instructions)
//   illegal             : held entry is unsupported
//   illegal_count       : saturating count of accepted illegal instructions
// -----------------------------------------------------------------------------
module alu_ctrl_stage #(
  parameter int NB_FUNCTION = 6,
  parameter int NB_OP       = 6,
  parameter int NB_OP_ALU   = 6,
  parameter int NB_DATA     = 32,
  parameter int NB_ERR_CNT  = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NB_OP-1:0]       opcode,
  input  logic [NB_FUNCTION-1:0] funct,
  input  logic [15:0]            imm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NB_OP_ALU-1:0]   funct_for_alu,
  output logic                   alu_src_imm,
  output logic                   shift_src_shamt,
  output logic [NB_DATA-1:0]     imm_ext,
  output logic                   illegal,
  output logic [NB_ERR_CNT-1:0]  illegal_count
);

  // ALU operation codes
  localparam logic [NB_OP_ALU-1:0] ALU_ADD = NB_OP_ALU'(6'b100000);
  localparam logic [NB_OP_ALU-1:0] ALU_SUB = NB_OP_ALU'(6'b100010);
  localparam logic [NB_OP_ALU-1:0] ALU_AND = NB_OP_ALU'(6'b100100);
  localparam logic [NB_OP_ALU-1:0] ALU_OR  = NB_OP_ALU'(6'b100101);
  localparam logic [NB_OP_ALU-1:0] ALU_XOR = NB_OP_ALU'(6'b100110);
  localparam logic [NB_OP_ALU-1:0] ALU_NOR = NB_OP_ALU'(6'b100111);
  localparam logic [NB_OP_ALU-1:0] ALU_SLT = NB_OP_ALU'(6'b101010);
  localparam logic [NB_OP_ALU-1:0] ALU_SLL = NB_OP_ALU'(6'b000000);
  localparam logic [NB_OP_ALU-1:0] ALU_SRL = NB_OP_ALU'(6'b000010);
  localparam logic [NB_OP_ALU-1:0] ALU_SRA = NB_OP_ALU'(6'b000011);
  localparam logic [NB_OP_ALU-1:0] ALU_LUI = NB_OP_ALU'(6'b001111);

  // Opcodes
  localparam logic [NB_OP-1:0] OP_RTYPE = NB_OP'(6'b000000);
  localparam logic [NB_OP-1:0] OP_ADDI  = NB_OP'(6'b001000);
  localparam logic [NB_OP-1:0] OP_SLTI  = NB_OP'(6'b001010);
  localparam logic [NB_OP-1:0] OP_ANDI  = NB_OP'(6'b001100);
  localparam logic [NB_OP-1:0] OP_ORI   = NB_OP'(6'b001101);
  localparam logic [NB_OP-1:0] OP_XORI  = NB_OP'(6'b001110);
  localparam logic [NB_OP-1:0] OP_LUI   = NB_OP'(6'b001111);

  // R-type funct values
  localparam logic [NB_FUNCTION-1:0] F_SLL  = NB_FUNCTION'(6'b000000);
  localparam logic [NB_FUNCTION-1:0] F_SRL  = NB_FUNCTION'(6'b000010);
  localparam logic [NB_FUNCTION-1:0] F_SRA  = NB_FUNCTION'(6'b000011);
  localparam logic [NB_FUNCTION-1:0] F_SLLV = NB_FUNCTION'(6'b000100);
  localparam logic [NB_FUNCTION-1:0] F_SRLV = NB_FUNCTION'(6'b000110);
  localparam logic [NB_FUNCTION-1:0] F_SRAV = NB_FUNCTION'(6'b000111);
  localparam logic [NB_FUNCTION-1:0] F_ADDU = NB_FUNCTION'(6'b100001);
  localparam logic [NB_FUNCTION-1:0] F_SUBU = NB_FUNCTION'(6'b100011);
  localparam logic [NB_FUNCTION-1:0] F_AND  = NB_FUNCTION'(6'b100100);
  localparam logic [NB_FUNCTION-1:0] F_OR   = NB_FUNCTION'(6'b100101);
  localparam logic [NB_FUNCTION-1:0] F_XOR  = NB_FUNCTION'(6'b100110);
  localparam logic [NB_FUNCTION-1:0] F_NOR  = NB_FUNCTION'(6'b100111);
  localparam logic [NB_FUNCTION-1:0] F_SLT  = NB_FUNCTION'(6'b101010);

  // Immediate extension variants. The size casts avoid zero-width
  // replications when NB_DATA is exactly 16.
  logic [NB_DATA-1:0] sign_ext;
  logic [NB_DATA-1:0] zero_ext;
  logic [NB_DATA-1:0] lui_ext;

  assign sign_ext = NB_DATA'($signed(imm));
  assign zero_ext = NB_DATA'(imm);
  assign lui_ext  = zero_ext << (NB_DATA - 16);

  // Combinational decode of the incoming fields
  logic [NB_OP_ALU-1:0] dec_alu;
  logic                 dec_src_imm;
  logic                 dec_shamt;
  logic [NB_DATA-1:0]   dec_ext;
  logic                 dec_illegal;

  always_comb begin
    dec_alu     = '0;
    dec_src_imm = 1'b0;
    dec_shamt   = 1'b0;
    dec_ext     = '0;
    dec_illegal = 1'b0;
    if (opcode == OP_RTYPE) begin
      case (funct)
        F_SLL:   begin dec_alu = ALU_SLL; dec_shamt = 1'b1; end
        F_SRL:   begin dec_alu = ALU_SRL; dec_shamt = 1'b1; end
        F_SRA:   begin dec_alu = ALU_SRA; dec_shamt = 1'b1; end
        F_SLLV:  dec_alu = ALU_SLL;
        F_SRLV:  dec_alu = ALU_SRL;
        F_SRAV:  dec_alu = ALU_SRA;
        F_ADDU:  dec_alu = ALU_ADD;
        F_SUBU:  dec_alu = ALU_SUB;
        F_AND:   dec_alu = ALU_AND;
        F_OR:    dec_alu = ALU_OR;
        F_XOR:   dec_alu = ALU_XOR;
        F_NOR:   dec_alu = ALU_NOR;
        F_SLT:   dec_alu = ALU_SLT;
        default: dec_illegal = 1'b1;
      endcase
    end else begin
      dec_src_imm = 1'b1;
      case (opcode)
        OP_ADDI: begin dec_alu = ALU_ADD; dec_ext = sign_ext; end
        OP_SLTI: begin dec_alu = ALU_SLT; dec_ext = sign_ext; end
        OP_ANDI: begin dec_alu = ALU_AND; dec_ext = zero_ext; end
        OP_ORI:  begin dec_alu = ALU_OR;  dec_ext = zero_ext; end
        OP_XORI: begin dec_alu = ALU_XOR; dec_ext = zero_ext; end
        OP_LUI:  begin dec_alu = ALU_LUI; dec_ext = lui_ext;  end
        default: begin
          dec_src_imm = 1'b0;
          dec_illegal = 1'b1;
        end
      endcase
    end
  end

  // Output register and handshake
  logic                  out_valid_reg;
  logic [NB_OP_ALU-1:0]  alu_reg;
  logic                  src_imm_reg;
  logic                  shamt_reg;
  logic [NB_DATA-1:0]    ext_reg;
  logic                  illegal_reg;
  logic [NB_ERR_CNT-1:0] cnt_reg;
  logic                  accept;
  logic                  consume;

  // While reset is held the register is about to be cleared, so upstream
  // sees the stage as empty.
  assign in_ready = (!out_valid_reg || out_ready || reset) && !flush;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid_reg && out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      alu_reg       <= '0;
      src_imm_reg   <= 1'b0;
      shamt_reg     <= 1'b0;
      ext_reg       <= '0;
      illegal_reg   <= 1'b0;
      cnt_reg       <= '0;
    end else if (flush) begin
      // Data fields keep stale values; only the valid flag is dropped.
      out_valid_reg <= 1'b0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      alu_reg       <= dec_alu;
      src_imm_reg   <= dec_src_imm;
      shamt_reg     <= dec_shamt;
      ext_reg       <= dec_ext;
      illegal_reg   <= dec_illegal;
      if (dec_illegal && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + NB_ERR_CNT'(1);
      end
    end else if (consume) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid       = out_valid_reg;
  assign funct_for_alu   = alu_reg;
  assign alu_src_imm     = src_imm_reg;
  assign shift_src_shamt = shamt_reg;
  assign imm_ext         = ext_reg;
  assign illegal         = illegal_reg;
  assign illegal_count   = cnt_reg;

endmodule
